// File: rtl/audipus_regmap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audipus_regmap_pkg
// Purpose  : Shared register-map constants for the SPI register bank:
//            register addresses, device ID and coefficient geometry.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package audipus_regmap_pkg;

  localparam int REG_ADDR_W = 7;

  localparam logic [REG_ADDR_W-1:0] REG_ID       = 7'h00;
  localparam logic [REG_ADDR_W-1:0] REG_CTRL     = 7'h01;
  localparam logic [REG_ADDR_W-1:0] REG_STATUS   = 7'h02;
  localparam logic [REG_ADDR_W-1:0] REG_COEF_PTR = 7'h03;
  localparam logic [REG_ADDR_W-1:0] REG_COEF_HI  = 7'h04;
  localparam logic [REG_ADDR_W-1:0] REG_COEF_MID = 7'h05;
  localparam logic [REG_ADDR_W-1:0] REG_COEF_LO  = 7'h06;
  localparam logic [REG_ADDR_W-1:0] REG_SCRATCH  = 7'h07;
  localparam logic [REG_ADDR_W-1:0] REG_EVENTS   = 7'h08;

  localparam logic [7:0] ID_VALUE = 8'hA5;

  // A coefficient is assembled from three SPI bytes: HI, MID, LO.
  localparam int COEF_BYTES = 3;
  localparam int COEF_WIDTH = 24;

endpackage : audipus_regmap_pkg
`default_nettype wire

// File: rtl/coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : coef_loader
// Purpose  : Stages HI/MID coefficient bytes, holds the auto-incrementing
//            coefficient pointer and emits a one-cycle commit strobe when the
//            LO byte is written.
// Ports    : clk, reset_n        - clock, async active-low reset
//            ptr_wr/hi_wr/mid_wr/lo_wr - decoded write enables
//            wr_data             - SPI write byte
//            coef_ptr            - current pointer (for readback)
//            coef_wr_stb/addr/data - commit to coefficient RAM
// Revision : 1.0 - initial release
// ============================================================================
module coef_loader
  import audipus_regmap_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int COEF_BITS      = COEF_WIDTH,
  parameter int COEF_ADDR_BITS = 8,
  parameter int NUM_COEFS      = 256
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ptr_wr,
  input  logic                      hi_wr,
  input  logic                      mid_wr,
  input  logic                      lo_wr,
  input  logic [DATA_BITS-1:0]      wr_data,
  output logic [COEF_ADDR_BITS-1:0] coef_ptr,
  output logic                      coef_wr_stb,
  output logic [COEF_ADDR_BITS-1:0] coef_wr_addr,
  output logic [COEF_BITS-1:0]      coef_wr_data
);

  logic [DATA_BITS-1:0]      hi_byte;
  logic [DATA_BITS-1:0]      mid_byte;
  logic [COEF_ADDR_BITS-1:0] ptr_inc;

  // Pointer wraps at the end of the populated coefficient range, which may be
  // smaller than the full address space.
  always_comb begin
    ptr_inc = coef_ptr + COEF_ADDR_BITS'(1);
    if (coef_ptr == COEF_ADDR_BITS'(NUM_COEFS - 1)) begin
      ptr_inc = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_byte      <= '0;
      mid_byte     <= '0;
      coef_ptr     <= '0;
      coef_wr_stb  <= 1'b0;
      coef_wr_addr <= '0;
      coef_wr_data <= '0;
    end else begin
      coef_wr_stb <= lo_wr;
      if (hi_wr) begin
        hi_byte <= wr_data;
      end
      if (mid_wr) begin
        mid_byte <= wr_data;
      end
      // The commit captures the pointer before it advances; HI/MID persist so
      // that coefficients sharing upper bytes only need a LO write each.
      if (lo_wr) begin
        coef_wr_addr <= coef_ptr;
        coef_wr_data <= COEF_BITS'({hi_byte, mid_byte, wr_data});
      end
      // An explicit pointer write overrides the post-commit increment.
      if (ptr_wr) begin
        coef_ptr <= COEF_ADDR_BITS'(wr_data);
      end else if (lo_wr) begin
        coef_ptr <= ptr_inc;
      end
    end
  end

endmodule : coef_loader
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bank
// Purpose  : Control/status register bank behind the SPI slave. Decodes
//            address and strobes, holds CTRL/SCRATCH/EVENTS, returns registered
//            read data and drives coefficient commits via coef_loader.
// Ports    : clk, reset_n                      - clock, async active-low reset
//            spi_addr/spi_write_data/strobes   - SPI register access
//            spi_read_data                     - registered read data
//            status_in, event_in               - live status, event pulses
//            ctrl_reg                          - control register
//            coef_wr_stb/addr/data             - coefficient RAM commit
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bank
  import audipus_regmap_pkg::*;
#(
  parameter int         ADDR_BITS      = 7,
  parameter int         DATA_BITS      = 8,
  parameter int         COEF_BITS      = COEF_WIDTH,
  parameter int         COEF_ADDR_BITS = 8,
  parameter int         NUM_COEFS      = 256,
  parameter logic [7:0] ID_VALUE       = audipus_regmap_pkg::ID_VALUE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_BITS-1:0]      spi_addr,
  input  logic [DATA_BITS-1:0]      spi_write_data,
  input  logic                      spi_write_stb,
  input  logic                      spi_read_stb,
  output logic [DATA_BITS-1:0]      spi_read_data,
  input  logic [7:0]                status_in,
  input  logic [7:0]                event_in,
  output logic [7:0]                ctrl_reg,
  output logic                      coef_wr_stb,
  output logic [COEF_ADDR_BITS-1:0] coef_wr_addr,
  output logic [COEF_BITS-1:0]      coef_wr_data
);

  logic                      sel_ctrl, sel_ptr, sel_hi, sel_mid, sel_lo;
  logic                      sel_scratch, sel_events;
  logic [7:0]                scratch_reg;
  logic [7:0]                event_flags;
  logic [COEF_ADDR_BITS-1:0] coef_ptr;
  logic [DATA_BITS-1:0]      read_mux;

  always_comb begin
    sel_ctrl    = (spi_addr == ADDR_BITS'(REG_CTRL));
    sel_ptr     = (spi_addr == ADDR_BITS'(REG_COEF_PTR));
    sel_hi      = (spi_addr == ADDR_BITS'(REG_COEF_HI));
    sel_mid     = (spi_addr == ADDR_BITS'(REG_COEF_MID));
    sel_lo      = (spi_addr == ADDR_BITS'(REG_COEF_LO));
    sel_scratch = (spi_addr == ADDR_BITS'(REG_SCRATCH));
    sel_events  = (spi_addr == ADDR_BITS'(REG_EVENTS));
  end

  // The mux reads current register contents, so a read issued together with
  // a write to the same register returns the pre-write value.
  always_comb begin
    read_mux = '0;
    if (spi_addr == ADDR_BITS'(REG_ID)) begin
      read_mux = DATA_BITS'(ID_VALUE);
    end else if (sel_ctrl) begin
      read_mux = DATA_BITS'(ctrl_reg);
    end else if (spi_addr == ADDR_BITS'(REG_STATUS)) begin
      read_mux = DATA_BITS'(status_in);
    end else if (sel_ptr) begin
      read_mux = DATA_BITS'(coef_ptr);
    end else if (sel_scratch) begin
      read_mux = DATA_BITS'(scratch_reg);
    end else if (sel_events) begin
      read_mux = DATA_BITS'(event_flags);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg      <= '0;
      scratch_reg   <= '0;
      event_flags   <= '0;
      spi_read_data <= '0;
    end else begin
      if (spi_write_stb && sel_ctrl) begin
        ctrl_reg <= 8'(spi_write_data);
      end
      if (spi_write_stb && sel_scratch) begin
        scratch_reg <= 8'(spi_write_data);
      end
      // A read clears exactly the flags it returned; a pulse arriving in the
      // same cycle is OR-ed in afterwards so it is never lost.
      if (spi_read_stb && sel_events) begin
        event_flags <= event_in;
      end else begin
        event_flags <= event_flags | event_in;
      end
      if (spi_read_stb) begin
        spi_read_data <= read_mux;
      end
    end
  end

  coef_loader #(
    .DATA_BITS      (DATA_BITS),
    .COEF_BITS      (COEF_BITS),
    .COEF_ADDR_BITS (COEF_ADDR_BITS),
    .NUM_COEFS      (NUM_COEFS)
  ) u_coef_loader (
    .clk          (clk),
    .reset_n      (reset_n),
    .ptr_wr       (spi_write_stb && sel_ptr),
    .hi_wr        (spi_write_stb && sel_hi),
    .mid_wr       (spi_write_stb && sel_mid),
    .lo_wr        (spi_write_stb && sel_lo),
    .wr_data      (spi_write_data),
    .coef_ptr     (coef_ptr),
    .coef_wr_stb  (coef_wr_stb),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data)
  );

endmodule : spi_reg_bank
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_bank
// Purpose  : Self-checking bench for spi_reg_bank. Inputs change on the
//            falling edge; outputs are compared on the following falling edge.
//            Expected reads and commits are queued when stimulus is driven and
//            popped when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  spi_addr;
  logic [7:0]  spi_write_data;
  logic        spi_write_stb;
  logic        spi_read_stb;
  logic [7:0]  spi_read_data;
  logic [7:0]  status_in;
  logic [7:0]  event_in;
  logic [7:0]  ctrl_reg;
  logic        coef_wr_stb;
  logic [7:0]  coef_wr_addr;
  logic [23:0] coef_wr_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } commit_t;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] status;
    logic [7:0] exp_rd;
    logic [7:0] exp_ctrl;
  } vec_t;

  logic [7:0] rd_q[$];
  commit_t    cm_q[$];
  logic       rd_flag = 1'b0;

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_addr       (spi_addr),
    .spi_write_data (spi_write_data),
    .spi_write_stb  (spi_write_stb),
    .spi_read_stb   (spi_read_stb),
    .spi_read_data  (spi_read_data),
    .status_in      (status_in),
    .event_in       (event_in),
    .ctrl_reg       (ctrl_reg),
    .coef_wr_stb    (coef_wr_stb),
    .coef_wr_addr   (coef_wr_addr),
    .coef_wr_data   (coef_wr_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Remember which captured edges carried an accepted read.
  always @(posedge clk) begin
    rd_flag <= spi_read_stb && reset_n;
  end

  always @(negedge clk) begin
    if (rd_flag) begin
      if (rd_q.size() == 0) begin
        check("unexpected_read", 32'd1, 32'd0);
      end else begin
        check("read_data", {24'h0, spi_read_data}, {24'h0, rd_q.pop_front()});
      end
    end
    if (coef_wr_stb) begin
      if (cm_q.size() == 0) begin
        check("unexpected_commit", 32'd1, 32'd0);
      end else begin
        commit_t c;
        c = cm_q.pop_front();
        check("commit_addr", {24'h0, coef_wr_addr}, {24'h0, c.addr});
        check("commit_data", {8'h0, coef_wr_data}, {8'h0, c.data});
      end
    end
  end

  // One cycle of stimulus: drive on the falling edge, hold through the rising
  // edge, then drop strobes/events at the next falling edge.
  task automatic step(input logic wr, input logic rd, input logic [6:0] a,
                      input logic [7:0] d, input logic [7:0] ev, input logic [7:0] exp_rd);
    spi_write_stb  = wr;
    spi_read_stb   = rd;
    spi_addr       = a;
    spi_write_data = d;
    event_in       = ev;
    if (rd) rd_q.push_back(exp_rd);
    @(negedge clk);
    spi_write_stb = 1'b0;
    spi_read_stb  = 1'b0;
    event_in      = 8'h00;
  endtask

  task automatic expect_commit(input logic [7:0] a, input logic [23:0] d);
    commit_t c;
    c.addr = a;
    c.data = d;
    cm_q.push_back(c);
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 7'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 7'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 7'h01, 8'h3C, 8'h00, 8'h00, 8'h3C};
    vecs[3]  = '{1'b0, 1'b1, 7'h01, 8'h00, 8'h00, 8'h3C, 8'h3C};
    vecs[4]  = '{1'b1, 1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, 8'h3C};
    vecs[5]  = '{1'b0, 1'b1, 7'h7F, 8'h00, 8'h00, 8'h00, 8'h3C};
    vecs[6]  = '{1'b0, 1'b1, 7'h01, 8'h00, 8'h00, 8'h3C, 8'h3C};
    vecs[7]  = '{1'b1, 1'b0, 7'h07, 8'hAA, 8'h00, 8'h00, 8'h3C};
    vecs[8]  = '{1'b0, 1'b1, 7'h07, 8'h00, 8'h00, 8'hAA, 8'h3C};
    vecs[9]  = '{1'b1, 1'b0, 7'h04, 8'h12, 8'h00, 8'h00, 8'h3C};
    vecs[10] = '{1'b0, 1'b1, 7'h04, 8'h00, 8'h00, 8'h00, 8'h3C};
    vecs[11] = '{1'b0, 1'b1, 7'h02, 8'h00, 8'h5A, 8'h5A, 8'h3C};
    vecs[12] = '{1'b0, 1'b1, 7'h06, 8'h00, 8'h00, 8'h00, 8'h3C};
    vecs[13] = '{1'b1, 1'b0, 7'h01, 8'hC3, 8'h00, 8'h00, 8'hC3};
    vecs[14] = '{1'b0, 1'b1, 7'h00, 8'h00, 8'h00, 8'hA5, 8'hC3};

    reset_n        = 1'b0;
    spi_addr       = 7'h00;
    spi_write_data = 8'h00;
    spi_write_stb  = 1'b0;
    spi_read_stb   = 1'b0;
    status_in      = 8'h00;
    event_in       = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_read_data", {24'h0, spi_read_data}, 32'h0);
    check("rst_ctrl", {24'h0, ctrl_reg}, 32'h0);
    check("rst_coef_stb", {31'h0, coef_wr_stb}, 32'h0);
    check("rst_coef_addr", {24'h0, coef_wr_addr}, 32'h0);
    check("rst_coef_data", {8'h0, coef_wr_data}, 32'h0);

    // Register map vectors.
    for (int i = 0; i < 15; i++) begin
      status_in = vecs[i].status;
      step(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, 8'h00, vecs[i].exp_rd);
      check("ctrl_reg", {24'h0, ctrl_reg}, {24'h0, vecs[i].exp_ctrl});
    end
    status_in = 8'h00;

    // Coefficient commits with pointer wrap; LO written back-to-back.
    step(1'b1, 1'b0, 7'h03, 8'hFE, 8'h00, 8'h00);
    step(1'b1, 1'b0, 7'h04, 8'h12, 8'h00, 8'h00);
    step(1'b1, 1'b0, 7'h05, 8'h34, 8'h00, 8'h00);
    expect_commit(8'hFE, 24'h123456);
    step(1'b1, 1'b0, 7'h06, 8'h56, 8'h00, 8'h00);
    expect_commit(8'hFF, 24'h123456);
    step(1'b1, 1'b0, 7'h06, 8'h56, 8'h00, 8'h00);
    step(1'b0, 1'b0, 7'h00, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 7'h03, 8'h00, 8'h00, 8'h00);

    // Sticky events, clear-on-read, set wins over clear.
    step(1'b0, 1'b0, 7'h00, 8'h00, 8'h05, 8'h00);
    step(1'b0, 1'b1, 7'h08, 8'h00, 8'h00, 8'h05);
    step(1'b0, 1'b1, 7'h08, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 7'h00, 8'h00, 8'h01, 8'h00);
    step(1'b0, 1'b1, 7'h08, 8'h00, 8'h01, 8'h01);
    step(1'b0, 1'b1, 7'h08, 8'h00, 8'h00, 8'h01);
    step(1'b0, 1'b1, 7'h08, 8'h00, 8'h00, 8'h00);

    // Reset in the middle of staging discards HI/MID.
    step(1'b1, 1'b0, 7'h04, 8'hAB, 8'h00, 8'h00);
    step(1'b1, 1'b0, 7'h05, 8'hCD, 8'h00, 8'h00);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_ctrl", {24'h0, ctrl_reg}, 32'h0);
    check("midrst_read_data", {24'h0, spi_read_data}, 32'h0);
    check("midrst_coef_data", {8'h0, coef_wr_data}, 32'h0);
    @(negedge clk);
    expect_commit(8'h00, 24'h000077);
    step(1'b1, 1'b0, 7'h06, 8'h77, 8'h00, 8'h00);

    // Pointer write right after a commit beats the increment.
    expect_commit(8'h01, 24'h000088);
    step(1'b1, 1'b0, 7'h06, 8'h88, 8'h00, 8'h00);
    step(1'b1, 1'b0, 7'h03, 8'h10, 8'h00, 8'h00);
    step(1'b0, 1'b1, 7'h03, 8'h00, 8'h00, 8'h10);

    // Simultaneous read and write: read sees the old value.
    step(1'b1, 1'b0, 7'h07, 8'hAA, 8'h00, 8'h00);
    step(1'b1, 1'b1, 7'h07, 8'h55, 8'h00, 8'hAA);
    step(1'b0, 1'b1, 7'h07, 8'h00, 8'h00, 8'h55);

    repeat (4) @(negedge clk);
    check("pending_reads", rd_q.size(), 32'd0);
    check("pending_commits", cm_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_spi_reg_bank
`default_nettype wire
